// File: rtl/egg_timer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : egg_timer_pkg
//  Description : Shared state encoding and timing constants for the
//                egg-timer sequencer and its key conditioning.
//  Revision    : 1.0 - initial release
// ============================================================================
package egg_timer_pkg;

    // Sequencer phases; 6 and 7 are unused and recover to S_IDLE.
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SET_SEC = 3'd1,
        S_SET_MIN = 3'd2,
        S_RUN     = 3'd3,
        S_PAUSE   = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    localparam int c_CLK_HZ_DEFAULT = 50_000_000;
    localparam int c_FLASH_DIV      = c_CLK_HZ_DEFAULT / 4;

    // Alarm flash period in clk cycles (four flashes per second, never zero).
    function automatic int flash_div(input int clk_hz);
        return (clk_hz / 4 > 0) ? clk_hz / 4 : 1;
    endfunction

    // Bits needed to hold 0..n-1 (at least one bit).
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_press_detect.sv
`default_nettype none
// ============================================================================
//  Module      : key_press_detect
//  Description : Synchronizes an active-low raw key, debounces it and emits a
//                single-cycle press strobe once per key hold.
//  Revision    : 1.0 - initial release
// ============================================================================
module key_press_detect
    import egg_timer_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_key_n,
    output logic o_press
);

    localparam int c_CNT_W = cnt_width(DEBOUNCE_CYC + 1);

    logic [1:0]         r_sync;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_press;
    logic               w_key_low;

    assign w_key_low = ~r_sync[1];
    assign o_press   = r_press;

    // Two-flop synchronizer; idles high so a reset never looks like a press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], i_key_n};
        end
    end

    // Low-time counter; saturating at DEBOUNCE_CYC acts as the release latch,
    // since only a high sample brings it back below the press threshold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (!w_key_low) begin
            r_cnt <= '0;
        end else if (r_cnt != c_CNT_W'(DEBOUNCE_CYC)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Strobe on the single cycle the counter steps onto the threshold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_press <= 1'b0;
        end else begin
            r_press <= w_key_low && (r_cnt == c_CNT_W'(DEBOUNCE_CYC - 1));
        end
    end

endmodule
`default_nettype wire

// File: rtl/egg_timer_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : egg_timer_sequencer
//  Description : Moore sequencer for the egg timer: conditions SET and START
//                keys, runs the 1 Hz decrement prescaler and alarm flasher.
//  Revision    : 1.0 - initial release
// ============================================================================
module egg_timer_sequencer
    import egg_timer_pkg::*;
#(
    parameter int CLK_HZ       = c_CLK_HZ_DEFAULT,
    parameter int DEBOUNCE_CYC = 500000,
    parameter int FLASH_SECS   = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       set_n,
    input  logic       start_n,
    input  logic       time_is_zero,
    output logic       sw_sec_en,
    output logic       sw_min_en,
    output logic       dec_pulse,
    output logic       flash_en,
    output logic       flash_tick,
    output logic       in_run,
    output logic [2:0] state_o
);

    localparam int c_FLASH_CYC = flash_div(CLK_HZ);
    localparam int c_SEC_W     = cnt_width(CLK_HZ);
    localparam int c_FLASH_W   = cnt_width(c_FLASH_CYC);
    localparam int c_SECS_W    = cnt_width(FLASH_SECS + 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_SEC_W-1:0]   r_sec_cnt;
    logic [c_FLASH_W-1:0] r_flash_cnt;
    logic [c_SECS_W-1:0]  r_done_secs;
    logic                 r_dec_pulse;
    logic                 r_flash_tick;

    logic w_set_press;
    logic w_start_press;
    logic w_state_change;
    logic w_timed;
    logic w_in_run;
    logic w_in_done;
    logic w_sec_wrap;
    logic w_flash_wrap;
    logic w_flash_expire;

    key_press_detect #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_set_key (
        .clk     (clk),
        .rst     (reset),
        .i_key_n (set_n),
        .o_press (w_set_press)
    );

    key_press_detect #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_start_key (
        .clk     (clk),
        .rst     (reset),
        .i_key_n (start_n),
        .o_press (w_start_press)
    );

    assign w_in_run       = (r_state == S_RUN);
    assign w_in_done      = (r_state == S_DONE);
    assign w_timed        = w_in_run || w_in_done;
    assign w_state_change = (w_state_nxt != r_state);
    assign w_sec_wrap     = w_timed && (r_sec_cnt == c_SEC_W'(CLK_HZ - 1));
    assign w_flash_wrap   = w_in_done && (r_flash_cnt == c_FLASH_W'(c_FLASH_CYC - 1));
    assign w_flash_expire = w_in_done && w_sec_wrap &&
                            (r_done_secs == c_SECS_W'(FLASH_SECS - 1));

    // Next-state logic; START is tested first so it wins a simultaneous press.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start_press) begin
                    if (!time_is_zero) w_state_nxt = S_RUN;
                end else if (w_set_press) begin
                    w_state_nxt = S_SET_SEC;
                end
            end
            S_SET_SEC: if (w_set_press) w_state_nxt = S_SET_MIN;
            S_SET_MIN: if (w_set_press) w_state_nxt = S_IDLE;
            S_RUN: begin
                if (time_is_zero)       w_state_nxt = S_DONE;
                else if (w_start_press) w_state_nxt = S_PAUSE;
            end
            S_PAUSE: begin
                if (w_start_press)    w_state_nxt = S_RUN;
                else if (w_set_press) w_state_nxt = S_SET_SEC;
            end
            S_DONE: begin
                if (w_set_press || w_start_press || w_flash_expire) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Second prescaler; cleared on any state change so every RUN/DONE entry
    // (including resume from PAUSE) starts a full second.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sec_cnt <= '0;
        end else if (w_state_change || !w_timed || w_sec_wrap) begin
            r_sec_cnt <= '0;
        end else begin
            r_sec_cnt <= r_sec_cnt + 1'b1;
        end
    end

    // Flash divider, running only while the alarm phase persists.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_flash_cnt <= '0;
        end else if (w_state_change || !w_in_done || w_flash_wrap) begin
            r_flash_cnt <= '0;
        end else begin
            r_flash_cnt <= r_flash_cnt + 1'b1;
        end
    end

    // Whole seconds spent in the alarm phase.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_done_secs <= '0;
        end else if (w_state_change || !w_in_done) begin
            r_done_secs <= '0;
        end else if (w_sec_wrap) begin
            r_done_secs <= r_done_secs + 1'b1;
        end
    end

    // Registered strobes; suppressed on the edge that leaves their phase so a
    // pulse never lands in the following state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dec_pulse  <= 1'b0;
            r_flash_tick <= 1'b0;
        end else begin
            r_dec_pulse  <= w_sec_wrap && w_in_run && (w_state_nxt == S_RUN);
            r_flash_tick <= w_flash_wrap && (w_state_nxt == S_DONE);
        end
    end

    assign sw_sec_en  = (r_state == S_SET_SEC);
    assign sw_min_en  = (r_state == S_SET_MIN);
    assign in_run     = w_in_run;
    assign flash_en   = w_in_done;
    assign state_o    = r_state;
    assign dec_pulse  = r_dec_pulse;
    assign flash_tick = r_flash_tick;

endmodule
`default_nettype wire
